sdram_rom_arbiter: RTL and testbench

// - Three-client read arbiter between ROM-side clients (68k program cache miss port,

---
 rtl/sdram_rom_arbiter_if.sv | 34 +++
 rtl/sdram_rom_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sdram_rom_arbiter.sv | 517 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_rom_arbiter_if.sv
// Bus bundle for sdram_rom_arbiter: three ROM-side read clients on one side,
// the single read port of the SDRAM controller on the other.
// The master modport is the arbiter's view. The slave modport is the
// environment's view (clients plus controller).
interface sdram_rom_arbiter_if #(
  parameter int AW     = 18,
  parameter int SDR_AW = 23,
  parameter int DW     = 16
);
  // Client side
  logic [2:0]        req;
  logic [AW-1:0]     addr0;
  logic [AW-1:0]     addr1;
  logic [AW-1:0]     addr2;
  logic [2:0]        valid;
  logic [DW-1:0]     data;

  // SDRAM controller side
  logic              sdr_req;
  logic [SDR_AW-1:0] sdr_addr;
  logic              sdr_ack;
  logic              sdr_valid;
  logic [DW-1:0]     sdr_data;

  modport master (
    input  req, addr0, addr1, addr2, sdr_ack, sdr_valid, sdr_data,
    output valid, data, sdr_req, sdr_addr
  );

  modport slave (
    output req, addr0, addr1, addr2, sdr_ack, sdr_valid, sdr_data,
    input  valid, data, sdr_req, sdr_addr
  );
endinterface

// File: rtl/sdram_rom_arbiter.sv
// Three-client read arbiter in front of the SDRAM controller read port.
// Clients are the 68k program cache miss port (0), tile fetch (1) and sound
// ROM (2). Each client word address is offset into its own SDRAM region, and
// only one SDRAM transaction is in flight at a time.
// A client is re-served only after it has dropped req at least once, so a
// client that keeps req high after its data returns is not served twice.
// Build option: define ARB_ROUND_ROBIN_EN for rotating priority; otherwise
// fixed priority 0 > 1 > 2.
module sdram_rom_arbiter #(
  parameter int                AW     = 18,
  parameter int                SDR_AW = 23,
  parameter int                DW     = 16,
  parameter logic [SDR_AW-1:0] BASE0  = 23'h000000,
  parameter logic [SDR_AW-1:0] BASE1  = 23'h040000,
  parameter logic [SDR_AW-1:0] BASE2  = 23'h100000
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_rom_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [2:0]        armed_q, armed_d;
  logic              sdr_req_q, sdr_req_d;
  logic [SDR_AW-1:0] sdr_addr_q, sdr_addr_d;
  logic [2:0]        valid_q, valid_d;
  logic [DW-1:0]     data_q, data_d;

  logic [2:0]        eligible;
  logic              any_eligible;
  logic [1:0]        pick;
  logic              grant_fire;
  logic [SDR_AW-1:0] mapped [3];

  // Region mapping: zero-extend the client word address and add the region
  // base; the sum wraps naturally at the SDRAM address width.
  assign mapped[0] = BASE0 + SDR_AW'(bus.addr0);
  assign mapped[1] = BASE1 + SDR_AW'(bus.addr1);
  assign mapped[2] = BASE2 + SDR_AW'(bus.addr2);

  assign eligible   = bus.req & armed_q;
  assign grant_fire = (state_q == IDLE) && any_eligible;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q;
  logic [1:0] slot;

  // Position k of the rotating search order that starts at base.
  function automatic logic [1:0] rr_slot(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Rotating-priority pick: first eligible client searching from rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    any_eligible = 1'b0;
    pick         = 2'd0;
    slot         = 2'd0;
    for (int k = 0; k < 3; k++) begin
      slot = rr_slot(rr_ptr_q, 2'(k));
      if (!any_eligible && eligible[slot]) begin
        any_eligible = 1'b1;
        pick         = slot;
      end
    end
  end

  // Pointer moves to the client after the one just granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 2'd0;
    end else if (grant_fire) begin
      rr_ptr_q <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
    end
  end
`else
  // Fixed-priority pick: client 0 beats 1 beats 2.
  always_comb begin
    any_eligible = |eligible;
    pick         = 2'd0;
    if (eligible[0])      pick = 2'd0;
    else if (eligible[1]) pick = 2'd1;
    else if (eligible[2]) pick = 2'd2;
  end
`endif

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    armed_d    = armed_q | ~bus.req;
    sdr_req_d  = sdr_req_q;
    sdr_addr_d = sdr_addr_q;
    valid_d    = 3'b000;
    data_d     = data_q;

    unique case (state_q)
      IDLE: begin
        if (any_eligible) begin
          grant_d       = pick;
          sdr_addr_d    = mapped[pick];
          sdr_req_d     = 1'b1;
          armed_d[pick] = 1'b0;
          state_d       = REQ;
        end
      end

      REQ: begin
        // A data beat arriving before the ack is ignored; one arriving with
        // the ack completes the transaction in the same cycle.
        if (bus.sdr_ack) begin
          sdr_req_d = 1'b0;
          if (bus.sdr_valid) begin
            data_d  = bus.sdr_data;
            valid_d = 3'b001 << grant_q;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (bus.sdr_valid) begin
          data_d  = bus.sdr_data;
          valid_d = 3'b001 << grant_q;
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        sdr_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of the others.
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 2'd0;
      armed_q    <= 3'b111;
      sdr_req_q  <= 1'b0;
      sdr_addr_q <= '0;
      valid_q    <= 3'b000;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      armed_q    <= armed_d;
      sdr_req_q  <= sdr_req_d;
      sdr_addr_q <= sdr_addr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign bus.sdr_req  = sdr_req_q;
  assign bus.sdr_addr = sdr_addr_q;
  assign bus.valid    = valid_q;
  assign bus.data     = data_q;

endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// Self-checking bench for sdram_rom_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_sdram_rom_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [22:0] BASE [3] = '{23'h000000, 23'h040000, 23'h100000};

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_rom_arbiter_if #(.AW(18), .SDR_AW(23), .DW(16)) bus  ();
  sdram_rom_arbiter_if #(.AW(18), .SDR_AW(23), .DW(16)) bus2 ();

  sdram_rom_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sdram_rom_arbiter #(.BASE2(23'h7FFFFF)) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected SDRAM address of client c with word address a.
  function automatic logic [22:0] map_addr(input int c, input logic [17:0] a);
    return BASE[c] + {5'd0, a};
  endfunction

  // Which pending client should win, given the rotating start point.
  function automatic int pick_winner(input logic [2:0] pend, input int rr);
    int start;
    start = RR_EN ? rr : 0;
    for (int k = 0; k < 3; k++) begin
      if (pend[(start + k) % 3]) return (start + k) % 3;
    end
    return 0;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset          = 1'b1;
    bus.req        = 3'b000;
    bus.addr0      = '0;
    bus.addr1      = '0;
    bus.addr2      = '0;
    bus.sdr_ack    = 1'b0;
    bus.sdr_valid  = 1'b0;
    bus.sdr_data   = '0;
    bus2.req       = 3'b000;
    bus2.addr0     = '0;
    bus2.addr1     = '0;
    bus2.addr2     = '0;
    bus2.sdr_ack   = 1'b0;
    bus2.sdr_valid = 1'b0;
    bus2.sdr_data  = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Plays the controller for one transaction: waits (bounded) for sdr_req,
  // acks after ack_dly cycles, returns d after dat_dly more cycles (or with
  // the ack when same is set). Ends at the sample point where valid is due.
  task automatic controller_txn(input int ack_dly, input int dat_dly, input logic same,
                                input logic [15:0] d, output logic ok,
                                output logic [22:0] addr_seen);
    ok        = 1'b0;
    addr_seen = '0;
    for (int i = 0; i < 20 && !bus.sdr_req; i++) tick;
    if (!bus.sdr_req) return;
    addr_seen = bus.sdr_addr;
    repeat (ack_dly) tick;
    bus.sdr_ack = 1'b1;
    if (same) begin
      bus.sdr_valid = 1'b1;
      bus.sdr_data  = d;
    end
    tick;
    bus.sdr_ack   = 1'b0;
    bus.sdr_valid = 1'b0;
    if (!same) begin
      repeat (dat_dly) tick;
      bus.sdr_valid = 1'b1;
      bus.sdr_data  = d;
      tick;
      bus.sdr_valid = 1'b0;
    end
    ok = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++;
    if (bus.sdr_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_sdr_req: got %b expected 0", bus.sdr_req);
    end
    n_checks++;
    if (bus.sdr_addr !== 23'h0) begin
      n_fail++; $display("FAIL reset_sdr_addr: got %h expected 000000", bus.sdr_addr);
    end
    n_checks++;
    if (bus.valid !== 3'b000) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 000", bus.valid);
    end
    n_checks++;
    if (bus.data !== 16'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0000", bus.data);
    end
  endtask

  task automatic test_single_client;
    do_reset;
    bus.req[0] = 1'b1;
    bus.addr0  = 18'h00123;
    tick;
    n_checks++;
    if (bus.sdr_req !== 1'b1) begin
      n_fail++; $display("FAIL single_req_latency: sdr_req got %b expected 1", bus.sdr_req);
    end
    n_checks++;
    if (bus.sdr_addr !== 23'h000123) begin
      n_fail++; $display("FAIL single_addr: got %h expected 000123", bus.sdr_addr);
    end
    tick;
    tick;
    n_checks++;
    if (bus.sdr_req !== 1'b1) begin
      n_fail++; $display("FAIL single_req_hold: got %b expected 1", bus.sdr_req);
    end
    bus.sdr_ack = 1'b1;
    tick;
    bus.sdr_ack = 1'b0;
    n_checks++;
    if (bus.sdr_req !== 1'b0) begin
      n_fail++; $display("FAIL single_req_drop: got %b expected 0", bus.sdr_req);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if (bus.valid !== 3'b000) begin
        n_fail++; $display("FAIL single_early_valid: got %b expected 000", bus.valid);
      end
    end
    bus.sdr_valid = 1'b1;
    bus.sdr_data  = 16'hBEEF;
    tick;
    bus.sdr_valid = 1'b0;
    n_checks++;
    if (bus.valid !== 3'b001 || bus.data !== 16'hBEEF) begin
      n_fail++; $display("FAIL single_valid: got valid=%b data=%h expected 001/beef",
                         bus.valid, bus.data);
    end
    tick;
    n_checks++;
    if (bus.valid !== 3'b000 || bus.data !== 16'hBEEF) begin
      n_fail++; $display("FAIL single_pulse_end: got valid=%b data=%h expected 000/beef",
                         bus.valid, bus.data);
    end
    bus.req[0] = 1'b0;
  endtask

  task automatic test_held_request;
    logic ok;
    logic [22:0] sa;
    logic [15:0] d;
    int highs;
    do_reset;
    d          = 16'($urandom);
    bus.req[0] = 1'b1;
    bus.addr0  = 18'($urandom);
    controller_txn(1, 2, 1'b0, d, ok, sa);
    n_checks++;
    if (ok !== 1'b1 || bus.valid !== 3'b001 || bus.data !== d) begin
      n_fail++; $display("FAIL held_first: ok=%b valid=%b data=%h expected 1/001/%h",
                         ok, bus.valid, bus.data, d);
    end
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (bus.sdr_req) highs++;
    end
    n_checks++;
    if (highs !== 0) begin
      n_fail++; $display("FAIL held_no_reserve: sdr_req high %0d cycles expected 0", highs);
    end
    bus.req[0] = 1'b0;
    tick;
    bus.req[0] = 1'b1;
    tick;
    n_checks++;
    if (bus.sdr_req !== 1'b1) begin
      n_fail++; $display("FAIL held_rearm: sdr_req got %b expected 1", bus.sdr_req);
    end
    d = 16'($urandom);
    controller_txn(0, 0, 1'b0, d, ok, sa);
    n_checks++;
    if (ok !== 1'b1 || bus.valid !== 3'b001 || bus.data !== d) begin
      n_fail++; $display("FAIL held_second: ok=%b valid=%b data=%h expected 1/001/%h",
                         ok, bus.valid, bus.data, d);
    end
    bus.req[0] = 1'b0;
  endtask

  task automatic test_contention;
    logic ok;
    logic [22:0] sa;
    logic [15:0] d;
    logic [17:0] a [3];
    int order [4];
    int n_txn;
    int w;
    int served;
    do_reset;
    order = '{0, 1, 2, 0};
    n_txn = RR_EN ? 4 : 3;
    for (int c = 0; c < 3; c++) a[c] = 18'($urandom);
    bus.addr0 = a[0];
    bus.addr1 = a[1];
    bus.addr2 = a[2];
    bus.req   = 3'b111;
    for (int t = 0; t < n_txn; t++) begin
      w = order[t];
      d = 16'($urandom);
      controller_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, d, ok, sa);
      n_checks++;
      if (ok !== 1'b1 || bus.valid !== (3'b001 << w)) begin
        n_fail++; $display("FAIL contention_order[%0d]: ok=%b valid=%b expected client %0d",
                           t, ok, bus.valid, w);
      end
      n_checks++;
      if (sa !== map_addr(w, a[w]) || bus.data !== d) begin
        n_fail++; $display("FAIL contention_addr_data[%0d]: addr=%h data=%h expected %h/%h",
                           t, sa, bus.data, map_addr(w, a[w]), d);
      end
      served = w;
      for (int c = 0; c < 3; c++) if (bus.valid[c]) served = c;
      bus.req[served] = 1'b0;
      tick;
      if (RR_EN && served == 0 && t == 0) begin
        a[0]       = 18'($urandom);
        bus.addr0  = a[0];
        bus.req[0] = 1'b1;
      end
    end
    bus.req = 3'b000;
  endtask

  task automatic test_addr_map;
    logic ok;
    logic [22:0] sa;
    logic [15:0] d;
    do_reset;
    d          = 16'($urandom);
    bus.req[2] = 1'b1;
    bus.addr2  = 18'h3FFFF;
    controller_txn(0, 1, 1'b0, d, ok, sa);
    n_checks++;
    if (ok !== 1'b1 || sa !== 23'h13FFFF || bus.valid !== 3'b100) begin
      n_fail++; $display("FAIL map_client2: addr=%h valid=%b expected 13ffff/100", sa, bus.valid);
    end
    bus.req[2] = 1'b0;
    tick;
    d          = 16'($urandom);
    bus.req[1] = 1'b1;
    bus.addr1  = 18'h3FFFF;
    controller_txn(0, 0, 1'b0, d, ok, sa);
    n_checks++;
    if (ok !== 1'b1 || sa !== 23'h07FFFF || bus.valid !== 3'b010) begin
      n_fail++; $display("FAIL map_client1: addr=%h valid=%b expected 07ffff/010", sa, bus.valid);
    end
    bus.req[1] = 1'b0;
    bus2.req   = 3'b100;
    bus2.addr2 = 18'd1;
    for (int i = 0; i < 10 && !bus2.sdr_req; i++) tick;
    n_checks++;
    if (bus2.sdr_req !== 1'b1 || bus2.sdr_addr !== 23'h000000) begin
      n_fail++; $display("FAIL map_wrap: sdr_req=%b addr=%h expected 1/000000",
                         bus2.sdr_req, bus2.sdr_addr);
    end
    bus2.req = 3'b000;
  endtask

  task automatic test_same_cycle_ack_valid;
    logic ok;
    logic [22:0] sa;
    logic [15:0] d;
    logic [17:0] a2;
    do_reset;
    d          = 16'($urandom);
    bus.req[1] = 1'b1;
    bus.addr1  = 18'($urandom);
    controller_txn(2, 0, 1'b1, d, ok, sa);
    n_checks++;
    if (ok !== 1'b1 || bus.valid !== 3'b010 || bus.data !== d || bus.sdr_req !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_valid: valid=%b data=%h sdr_req=%b expected 010/%h/0",
                         bus.valid, bus.data, bus.sdr_req, d);
    end
    a2         = 18'($urandom);
    bus.req    = 3'b100;
    bus.addr2  = a2;
    tick;
    n_checks++;
    if (bus.valid !== 3'b000) begin
      n_fail++; $display("FAIL same_cycle_single_pulse: valid=%b expected 000", bus.valid);
    end
    n_checks++;
    if (bus.sdr_req !== 1'b1 || bus.sdr_addr !== map_addr(2, a2)) begin
      n_fail++; $display("FAIL same_cycle_back_idle: sdr_req=%b addr=%h expected 1/%h",
                         bus.sdr_req, bus.sdr_addr, map_addr(2, a2));
    end
    bus.req = 3'b000;
  endtask

  task automatic test_reset_mid_transaction;
    logic ok;
    logic [22:0] sa;
    logic [15:0] d;
    logic [17:0] a1;
    do_reset;
    a1         = 18'($urandom);
    bus.req[1] = 1'b1;
    bus.addr1  = a1;
    for (int i = 0; i < 10 && !bus.sdr_req; i++) tick;
    bus.sdr_ack = 1'b1;
    tick;
    bus.sdr_ack = 1'b0;
    reset       = 1'b1;
    tick;
    n_checks++;
    if (bus.sdr_req !== 1'b0 || bus.valid !== 3'b000 || bus.data !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid: sdr_req=%b valid=%b data=%h expected 0/000/0000",
                         bus.sdr_req, bus.valid, bus.data);
    end
    reset         = 1'b0;
    bus.sdr_valid = 1'b1;
    bus.sdr_data  = 16'h1234;
    tick;
    bus.sdr_valid = 1'b0;
    n_checks++;
    if (bus.valid !== 3'b000 || bus.data !== 16'h0) begin
      n_fail++; $display("FAIL reset_late_valid: valid=%b data=%h expected 000/0000",
                         bus.valid, bus.data);
    end
    n_checks++;
    if (bus.sdr_req !== 1'b1 || bus.sdr_addr !== map_addr(1, a1)) begin
      n_fail++; $display("FAIL reset_reserve: sdr_req=%b addr=%h expected 1/%h",
                         bus.sdr_req, bus.sdr_addr, map_addr(1, a1));
    end
    d = 16'($urandom);
    controller_txn(0, 1, 1'b0, d, ok, sa);
    n_checks++;
    if (ok !== 1'b1 || bus.valid !== 3'b010 || bus.data !== d) begin
      n_fail++; $display("FAIL reset_reserve_data: valid=%b data=%h expected 010/%h",
                         bus.valid, bus.data, d);
    end
    bus.req = 3'b000;
  endtask

  // Random clients and a random-latency controller. The model tracks pending
  // clients, the rotating start point and the data it handed out.
  task automatic test_random;
    logic [2:0]  req_drv;
    logic [17:0] ca [3];
    int          drop_cnt [3];
    logic        sr_prev, dut_idle, rise, valid_due;
    int          rr_m, cur_w, phase, cnt;
    logic [22:0] cur_addr;
    logic [15:0] exp_data, d_due;
    logic [2:0]  exp_valid;
    do_reset;
    req_drv   = 3'b000;
    sr_prev   = 1'b0;
    dut_idle  = 1'b1;
    valid_due = 1'b0;
    rr_m      = 0;
    cur_w     = 0;
    cur_addr  = '0;
    phase     = 0;
    cnt       = 0;
    exp_data  = 16'h0;
    d_due     = 16'h0;
    for (int c = 0; c < 3; c++) begin
      ca[c]       = '0;
      drop_cnt[c] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick;
      rise = bus.sdr_req && !sr_prev;
      if (dut_idle) begin
        n_checks++;
        if (bus.sdr_req !== (req_drv != 3'b000)) begin
          n_fail++; $display("FAIL rnd_grant_start @%0d: sdr_req=%b pending=%b",
                             cyc, bus.sdr_req, req_drv);
        end
      end
      if (rise) begin
        n_checks++;
        if (!dut_idle) begin
          n_fail++; $display("FAIL rnd_unexpected_req @%0d: sdr_req rose while busy", cyc);
        end
        cur_w    = pick_winner(req_drv, rr_m);
        rr_m     = (cur_w + 1) % 3;
        cur_addr = map_addr(cur_w, ca[cur_w]);
        dut_idle = 1'b0;
        n_checks++;
        if (bus.sdr_addr !== cur_addr) begin
          n_fail++; $display("FAIL rnd_addr @%0d: got %h expected %h (client %0d)",
                             cyc, bus.sdr_addr, cur_addr, cur_w);
        end
      end else if (bus.sdr_req) begin
        n_checks++;
        if (bus.sdr_addr !== cur_addr) begin
          n_fail++; $display("FAIL rnd_addr_hold @%0d: got %h expected %h",
                             cyc, bus.sdr_addr, cur_addr);
        end
      end
      exp_valid = valid_due ? (3'b001 << cur_w) : 3'b000;
      if (valid_due) exp_data = d_due;
      n_checks++;
      if (bus.valid !== exp_valid || bus.data !== exp_data) begin
        n_fail++; $display("FAIL rnd_valid @%0d: valid=%b data=%h expected %b/%h",
                           cyc, bus.valid, bus.data, exp_valid, exp_data);
      end
      if (valid_due) begin
        dut_idle         = 1'b1;
        req_drv[cur_w]   = 1'b0;
        drop_cnt[cur_w]  = int'($urandom_range(1, 3));
      end
      sr_prev = bus.sdr_req;

      bus.sdr_ack   = 1'b0;
      bus.sdr_valid = 1'b0;
      valid_due     = 1'b0;
      if (phase == 0 && bus.sdr_req) begin
        phase = 1;
        cnt   = int'($urandom_range(0, 3));
      end
      if (phase == 1) begin
        if (cnt == 0) begin
          bus.sdr_ack = 1'b1;
          if ($urandom_range(0, 3) == 0) begin
            d_due         = 16'($urandom);
            bus.sdr_valid = 1'b1;
            bus.sdr_data  = d_due;
            valid_due     = 1'b1;
            phase         = 0;
          end else begin
            phase = 2;
            cnt   = int'($urandom_range(0, 3));
          end
        end else begin
          cnt--;
        end
      end else if (phase == 2) begin
        if (cnt == 0) begin
          d_due         = 16'($urandom);
          bus.sdr_valid = 1'b1;
          bus.sdr_data  = d_due;
          valid_due     = 1'b1;
          phase         = 0;
        end else begin
          cnt--;
        end
      end

      for (int c = 0; c < 3; c++) begin
        if (!req_drv[c]) begin
          if (drop_cnt[c] > 0) drop_cnt[c]--;
          else if ($urandom_range(0, 3) == 0) begin
            req_drv[c] = 1'b1;
            ca[c]      = 18'($urandom);
          end
        end
      end
      bus.req   = req_drv;
      bus.addr0 = ca[0];
      bus.addr1 = ca[1];
      bus.addr2 = ca[2];
    end
  endtask

  initial begin
    test_reset;
    test_single_client;
    test_held_request;
    test_contention;
    test_addr_map;
    test_same_cycle_ack_valid;
    test_reset_mid_transaction;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
